// File: rtl/systolic_feed_sequencer.sv
// Feeds one N x N job into an output-stationary systolic array: clear, skewed feed, drain, capture.
// Define FEEDER_TRANSPOSE_B_EN to take i_B as B transposed (column-major host layout).
module systolic_feed_sequencer #(
    parameter int W      = 16,
    parameter int N      = 3,
    parameter int PE_LAT = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [W*N*N-1:0] i_A,
    input  logic [W*N*N-1:0] i_B,
    output logic             o_busy,
    output logic             o_acc_clr,
    output logic             o_feed_valid,
    output logic [W*N-1:0]   o_a_row,
    output logic [W*N-1:0]   o_b_col,
    output logic             o_capture,
    output logic             o_done
);

    localparam int TW = $clog2(3*N-1);
    localparam int DW = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(3*N-3);
    localparam logic [DW-1:0] D_LAST = DW'(PE_LAT-1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [TW-1:0]      r_t;
    logic [DW-1:0]      r_d;
    logic [W*N*N-1:0]   r_A;
    logic [W*N*N-1:0]   r_B;
    logic               w_busy;
    logic               w_clr;
    logic               w_feed;
    logic               w_done;
    logic [W*N-1:0]     w_a;
    logic [W*N-1:0]     w_b;

    // Outputs are registered copies of the current-state decode, so they trail the state by one edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_t          <= '0;
            r_d          <= '0;
            r_A          <= '0;
            r_B          <= '0;
            o_busy       <= 1'b0;
            o_acc_clr    <= 1'b0;
            o_feed_valid <= 1'b0;
            o_a_row      <= '0;
            o_b_col      <= '0;
            o_capture    <= 1'b0;
            o_done       <= 1'b0;
        end else begin
            r_state <= w_next;
            r_t     <= (r_state == S_FEED && w_next == S_FEED) ? r_t + TW'(1) : '0;
            r_d     <= (r_state == S_DRAIN && w_next == S_DRAIN) ? r_d + DW'(1) : '0;
            if (r_state == S_IDLE && w_next == S_CLEAR) begin
                r_A <= i_A;
                r_B <= i_B;
            end
            o_busy       <= w_busy;
            o_acc_clr    <= w_clr;
            o_feed_valid <= w_feed;
            o_a_row      <= w_a;
            o_b_col      <= w_b;
            o_capture    <= w_done;
            o_done       <= w_done;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (i_start) w_next = S_CLEAR;
            S_CLEAR: w_next = S_FEED;
            S_FEED:  if (r_t == T_LAST) w_next = S_DRAIN;
            S_DRAIN: if (r_d == D_LAST) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (i_abort) w_next = S_IDLE;
    end

    always_comb begin
        w_busy = (r_state != S_IDLE);
        w_clr  = (r_state == S_CLEAR);
        w_feed = (r_state == S_FEED);
        w_done = (r_state == S_DONE);
        w_a    = '0;
        w_b    = '0;
        if (r_state == S_FEED) begin
            for (int i = 0; i < N; i++) begin
                if (int'(r_t) >= i && int'(r_t) - i < N) begin
                    w_a[i*W +: W] = r_A[(N*N-1-(i*N+int'(r_t)-i))*W +: W];
`ifdef FEEDER_TRANSPOSE_B_EN
                    w_b[i*W +: W] = r_B[(N*N-1-(i*N+int'(r_t)-i))*W +: W];
`else
                    w_b[i*W +: W] = r_B[(N*N-1-((int'(r_t)-i)*N+i))*W +: W];
`endif
                end
            end
        end
        // Abort suppresses everything, including a DONE that would otherwise fire now.
        if (i_abort) begin
            w_busy = 1'b0;
            w_clr  = 1'b0;
            w_feed = 1'b0;
            w_done = 1'b0;
            w_a    = '0;
            w_b    = '0;
        end
    end

endmodule

// File: tb/tb_systolic_feed_sequencer.sv
// Randomized bench for systolic_feed_sequencer against a job-timeline model.
// Follows FEEDER_TRANSPOSE_B_EN when the design is built with it.
module tb_systolic_feed_sequencer;

    localparam int W      = 16;
    localparam int N      = 3;
    localparam int PE_LAT = 2;
    localparam int L      = 3*N + PE_LAT;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic [W*N*N-1:0] A;
    logic [W*N*N-1:0] B;
    logic             o_busy;
    logic             o_acc_clr;
    logic             o_feed_valid;
    logic [W*N-1:0]   o_a_row;
    logic [W*N-1:0]   o_b_col;
    logic             o_capture;
    logic             o_done;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    // Job model: active + age (edges since the accepting edge) plus the latched matrices.
    bit           active = 1'b0;
    int           age = 0;
    logic [W-1:0] mA [N][N];
    logic [W-1:0] mB [N][N];

    systolic_feed_sequencer #(.W(W), .N(N), .PE_LAT(PE_LAT)) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_start(start),
        .i_abort(abort),
        .i_A(A),
        .i_B(B),
        .o_busy(o_busy),
        .o_acc_clr(o_acc_clr),
        .o_feed_valid(o_feed_valid),
        .o_a_row(o_a_row),
        .o_b_col(o_b_col),
        .o_capture(o_capture),
        .o_done(o_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active = 1'b0;
            age    = 0;
        end else if (active && age < L) begin
            if (abort) active = 1'b0;
            else age = age + 1;
        end else if (start && !abort) begin
            active = 1'b1;
            age    = 0;
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++) begin
                    mA[r][c] = A[(N*N-1-(r*N+c))*W +: W];
                    mB[r][c] = B[(N*N-1-(r*N+c))*W +: W];
                end
        end else begin
            active = 1'b0;
        end
    end

    always @(negedge clk) begin
        int p, t;
        logic e_busy, e_clr, e_feed, e_done;
        logic [W*N-1:0] ea, eb;
        p      = active ? age : -1;
        e_busy = (p >= 1 && p <= L);
        e_clr  = (p == 1);
        e_feed = (p >= 2 && p <= 3*N-1);
        e_done = (p == L);
        ea = '0;
        eb = '0;
        if (e_feed) begin
            t = p - 2;
            for (int i = 0; i < N; i++)
                if (t - i >= 0 && t - i < N) begin
                    ea[i*W +: W] = mA[i][t-i];
`ifdef FEEDER_TRANSPOSE_B_EN
                    eb[i*W +: W] = mB[i][t-i];
`else
                    eb[i*W +: W] = mB[t-i][i];
`endif
                end
        end
        checks++;
        if ({o_busy, o_acc_clr, o_feed_valid, o_capture, o_done} !==
            {e_busy, e_clr, e_feed, e_done, e_done} ||
            o_a_row !== ea || o_b_col !== eb) begin
            errors++;
            $display("FAIL model t=%0t: got bcfpd=%b%b%b%b%b a=%h b=%h, expected bcfpd=%b%b%b%b%b a=%h b=%h",
                     $time, o_busy, o_acc_clr, o_feed_valid, o_capture, o_done, o_a_row, o_b_col,
                     e_busy, e_clr, e_feed, e_done, e_done, ea, eb);
        end
        if (o_done === 1'b1) done_cnt++;
    end

    task automatic chk(input string nm, input logic [W*N-1:0] act, input logic [W*N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic rand_mats();
        for (int e = 0; e < N*N; e++) begin
            A[e*W +: W] = W'($urandom);
            B[e*W +: W] = W'($urandom);
        end
    endtask

    task automatic start_job();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int feeds, d0;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        A = '0;
        B = '0;

        repeat (4) begin
            tick();
            start = 1'($urandom);
            rand_mats();
            chk("rst_busy", W*N'(o_busy), '0);
            chk("rst_abus", o_a_row, '0);
            chk("rst_bbus", o_b_col, '0);
        end
        tick();
        start = 1'b0;
        rst_n = 1'b1;
        repeat (3) tick();
        chk("idle_busy", W*N'(o_busy), '0);

        // Skew pattern with A = B = 1..9 row-major; matrices scrambled right after the latch.
        for (int e = 0; e < N*N; e++) begin
            A[(N*N-1-e)*W +: W] = W'(e+1);
            B[(N*N-1-e)*W +: W] = W'(e+1);
        end
        start_job();
        rand_mats();
        feeds = 0;
        for (int p = 0; p < 14; p++) begin
            chk($sformatf("clr_p%0d", p), W*N'(o_acc_clr), W*N'(p == 1));
            chk($sformatf("done_p%0d", p), W*N'(o_done), W*N'(p == 11));
            chk($sformatf("busy_p%0d", p), W*N'(o_busy), W*N'(p >= 1 && p <= 11));
            if (p == 2) chk("a_t0", o_a_row, {16'd0, 16'd0, 16'd1});
            if (p == 4) begin
                chk("a_t2", o_a_row, {16'd7, 16'd5, 16'd3});
`ifdef FEEDER_TRANSPOSE_B_EN
                chk("b_t2", o_b_col, {16'd7, 16'd5, 16'd3});
`else
                chk("b_t2", o_b_col, {16'd3, 16'd5, 16'd7});
`endif
            end
            if (p == 6) begin
                chk("a_t4", o_a_row, {16'd9, 16'd0, 16'd0});
                chk("b_t4", o_b_col, {16'd9, 16'd0, 16'd0});
            end
            if (o_feed_valid) feeds++;
            tick();
        end
        chk("feed_len", W*N'(feeds), W*N'(7));

        // Start while busy is ignored.
        rand_mats();
        d0 = done_cnt;
        start_job();
        repeat (3) tick();
        rand_mats();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (20) tick();
        chk("busy_start_dones", W*N'(done_cnt - d0), W*N'(1));

        // Abort while t=3 is on the buses.
        rand_mats();
        start_job();
        repeat (5) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", W*N'(o_busy), '0);
        chk("abort_abus", o_a_row, '0);
        d0 = done_cnt;
        repeat (20) tick();
        chk("abort_nodone", W*N'(done_cnt - d0), '0);
        rand_mats();
        start_job();
        repeat (14) tick();
        chk("after_abort_done", W*N'(done_cnt - d0), W*N'(1));

        // Asynchronous reset in the middle of DRAIN.
        rand_mats();
        start_job();
        repeat (9) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", W*N'(o_busy), '0);
        chk("arst_abus", o_a_row, '0);
        chk("arst_bbus", o_b_col, '0);
        chk("arst_feed", W*N'(o_feed_valid), '0);
        d0 = done_cnt;
        tick();
        tick();
        rst_n = 1'b1;
        repeat (20) tick();
        chk("arst_nodone", W*N'(done_cnt - d0), '0);

        // Random traffic against the model.
        repeat (3000) begin
            tick();
            start = ($urandom % 4 == 0);
            abort = ($urandom % 40 == 0);
            rand_mats();
        end
        start = 1'b0;
        abort = 1'b0;
        repeat (15) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/systolic_feed_sequencer.md
Name: systolic_feed_sequencer

Overview:
- Sequences one N x N matrix-multiply job through the output-stationary systolic PE array behind the `control` unit.
- On start it latches A and B, clears the PE accumulators, then streams skewed A rows (west edge) and B columns (north edge) into the array.
- It then waits out the PE pipeline latency and pulses capture/done so `control` can read C.
- Handshake: start/busy/done, with a synchronous abort.

Parameters:
- W, 16, operand width in bits (FP16 bit pattern, passed through untouched)
- N, 3, array dimension (rows = cols = N), N >= 2
- PE_LAT, 2, cycles from the last operand entering PE(N-1,N-1) until its accumulator is valid, >= 1

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_start  in  1  job request; sampled only in IDLE
- i_abort  in  1  synchronous abort; returns to IDLE without done
- i_A  in  W*N*N  matrix A, row-major; element (r,c) at bits [(N*N-1-(r*N+c))*W +: W], so (0,0) is in the MSBs
- i_B  in  W*N*N  matrix B, same layout
- o_busy  out  1  high in every state except IDLE
- o_acc_clr  out  1  one-cycle accumulator clear to all PEs
- o_feed_valid  out  1  high while skewed operands are driven
- o_a_row  out  W*N  lane i (bits [i*W +: W]) feeds array row i
- o_b_col  out  W*N  lane j (bits [j*W +: W]) feeds array column j
- o_capture  out  1  one-cycle strobe: C valid in PEs, latch now
- o_done  out  1  one-cycle job-complete pulse, coincident with o_capture

Behaviour:
- Reset (i_rst_n low, async): state IDLE, feed counter 0, latched A/B cleared. All outputs are 0, including the o_a_row and o_b_col buses.
- All outputs are registered.
- FSM states: IDLE -> CLEAR -> FEED -> DRAIN -> DONE -> IDLE.
- IDLE:
  - i_start=1 at an edge latches i_A and i_B, enters CLEAR.
  - i_A/i_B changes after the latch have no effect on the job.
- CLEAR: exactly 1 cycle with o_acc_clr=1, then FEED with t=0.
- FEED: 3N-2 cycles, t = 0..3N-3, with o_feed_valid=1.
  - Lane i of o_a_row = A(i, t-i) if 0 <= t-i < N, else 0.
  - Lane j of o_b_col = B(t-j, j) if 0 <= t-j < N, else 0.
  - At t=3N-3 the state goes to DRAIN.
- DRAIN: PE_LAT cycles with o_feed_valid=0 and operand buses 0.
- DONE: 1 cycle with o_done=1 and o_capture=1, then IDLE.
- Latency: with the start sampled at edge k, o_acc_clr is high in the cycle after edge k+1. o_done is high in the cycle after edge k + 3N + PE_LAT; for N=3, PE_LAT=2 that is edge k+11. Back-to-back jobs are therefore possible every 3N+PE_LAT+1 cycles.
- i_start while busy: ignored, no queueing.
- i_abort=1 in any non-IDLE state: next state IDLE and all outputs 0. No o_done or o_capture is issued, even if abort coincides with DONE (abort wins).
- i_abort together with i_start in IDLE: abort wins, job not accepted.
- Reset asserted mid-job: immediate IDLE and all outputs 0. After release, no spurious done is produced.
- Feed counter width is clog2(3N-1). It must not wrap within a job.

Optional Feature:
- Macro FEEDER_TRANSPOSE_B_EN.
- When defined: i_B is interpreted as B transposed, so lane j of o_b_col = i_B element (j, t-j). This lets the host supply column-major B.
- When undefined: behaviour as above.
- No port or timing change either way.

Test Plan:
- Reset value check: hold i_rst_n=0 with random i_start -> all outputs 0, o_busy=0. Release -> outputs still 0 until a start.
- Skew pattern, N=3, PE_LAT=2: A = B = 16'h0001..16'h0009 row-major.
  - t=0: o_a_row lanes {1,0,0}.
  - t=2: a lanes {3,5,7}, b lanes {7,5,3}.
  - t=4: a lanes {0,0,9}, b lanes {0,0,9}.
  - o_feed_valid high for exactly 7 cycles.
- Timing: start at edge k -> o_acc_clr only after edge k+1, o_done/o_capture only after edge k+11, o_busy high from k+1 through k+11.
- Start while busy: pulse i_start during FEED with new A -> ignored, streamed values remain the latched matrix, exactly one o_done.
- Abort: assert i_abort at FEED t=3 -> IDLE next cycle, buses 0, no o_done within 20 cycles. A fresh start then completes normally.
- Async reset mid-DRAIN: drop i_rst_n between edges -> outputs 0 immediately without waiting for a clock edge, and no done after release.
